memory1_issue_unit: RTL and testbench
=====================================

# memory1_issue_unit

Memory-1 stage of the seven-stage pipeline, directly downstream of the execute→memory1 pipeline register. It turns the load/store held in memory1 into exactly one data-cache request using a valid/ready handshake, and waits for load responses. Load data is aligned and sign-extended, and results are registered into memory2. It drives the memory1 stall back upstream and inserts bubbles into memory2 while an access is pending.

## Interface
Parameters:
- DATA_WIDTH, 32, datapath width (fixed at 32 for byte-lane logic)
- ADDRESS_BITS, 20, data-cache address width; address = ALU_result_memory1[ADDRESS_BITS-1:0]

Ports:
- clock  in  1  sole clock
- reset  in  1  synchronous, active-high
- ALU_result_memory1 / store_data_memory1  in  DATA_WIDTH  effective address / store data
- rd_memory1  in  5;  opcode_memory1  in  7;  instruction_memory1  in  DATA_WIDTH;  PC_memory1  in  ADDRESS_BITS
- memRead_memory1, memWrite_memory1, regWrite_memory1  in  1  stage controls
- stall_wb  in  1  downstream hold
- dcache_req_valid  out  1;  dcache_req_write  out  1;  dcache_req_addr  out  ADDRESS_BITS (word-aligned, [1:0]=0)
- dcache_req_wdata  out  DATA_WIDTH;  dcache_req_byte_en  out  4
- dcache_ready  in  1  cache accepts request this cycle
- dcache_resp_valid  in  1;  dcache_resp_data  in  DATA_WIDTH  load response word
- stall_memory1  out  1  hold memory1 register (combinational)
- load_data_memory2, ALU_result_memory2  out  DATA_WIDTH;  rd_memory2  out  5;  opcode_memory2  out  7
- regWrite_memory2, memRead_memory2  out  1;  instruction_memory2  out  DATA_WIDTH;  PC_memory2  out  ADDRESS_BITS
- misaligned_memory2  out  1  misaligned-access flag (see Configuration)

## Operation
- funct3 = instruction_memory1[14:12]; off = ALU_result_memory1[1:0]; mem_op = memRead_memory1 | memWrite_memory1.
- FSM states: IDLE, WAIT_RESP, DONE. Reset → IDLE.
- IDLE with mem_op: dcache_req_valid=1. The request is accepted when dcache_req_valid & dcache_ready.
  - Accepted store → DONE if stall_wb, else stays IDLE (retired).
  - Accepted load → WAIT_RESP.
- WAIT_RESP: dcache_req_valid=0. On dcache_resp_valid, the aligned result goes to the internal load buffer. Next state is DONE if stall_wb, else IDLE (retired).
- DONE: the op is complete but held. No new request is issued. → IDLE on the first edge with stall_wb=0.
- Each memory1 instruction is issued exactly once. A dcache_resp_valid seen in IDLE or DONE is ignored.
- Store encoding:
  - SB: byte_en=1<<off, wdata={4{store_data[7:0]}}
  - SH: byte_en=3<<off, wdata={2{store_data[15:0]}}
  - SW: byte_en=4'hF, wdata=store_data
  - Loads: byte_en=4'hF, write=0.
- Load alignment: select resp_data >> (8*off).
  - LB/LH: sign-extend from bit 7/15.
  - LBU/LHU: zero-extend.
  - LW: full word.
- stall_memory1 = mem_op & ~complete_now & state≠DONE.
  - complete_now = store accepted this cycle, or (WAIT_RESP & dcache_resp_valid).
- memory2 register update, in priority order:
  - reset: all zero, instruction_memory2=32'h00000013.
  - stall_wb: hold all.
  - stall_memory1: bubble (regWrite_memory2=0, memRead_memory2=0, misaligned_memory2=0, instruction NOP, other fields hold).
  - else: load from memory1; load_data_memory2 = response this cycle, or the buffer when state was DONE.
- Reset mid-access drops dcache_req_valid in the same cycle the reset is sampled. A response that arrives afterwards is ignored.

## Timing
- Reset values: dcache_req_valid=0, stall_memory1=0 (while mem_op=0), all memory2 outputs 0 except instruction_memory2=NOP.
- Store, dcache_ready=1: zero stall cycles; memory2 updates at the end of the issue cycle.
- Load, ready in cycle N, response in N+k (k≥1): stall_memory1 is high in cycles N..N+k-1. memory2 holds the load data after the edge ending N+k.
- dcache_ready low: request stays asserted with stable addr/wdata/byte_en until accepted.
- Responses never arrive in the acceptance cycle; the earliest is the next cycle.

## Configuration
- MISALIGNED_TRAP_EN defined:
  - A misaligned access (H with off[0]=1; W with off≠0) issues no request and does not stall.
  - memory2 receives misaligned_memory2=1, regWrite_memory2=0, memRead_memory2=0 and the PC/instruction.
- MISALIGNED_TRAP_EN undefined:
  - Misaligned H/W accesses issue as the low lanes of the aligned word, i.e. off is treated as 0 for H/W.
  - misaligned_memory2 is tied to 0.

## Test plan
- SW addr 0x100, data 0xDEADBEEF, ready=1 → one-cycle req_valid, write=1, addr 0x100, byte_en F, no stall.
- SB addr 0x103, data 0x000000A5 → byte_en 4'b1000, wdata 0xA5A5A5A5.
- LB addr 0x102, resp 0x12807F00 after 3 cycles → stall high 3 cycles; load_data_memory2=0xFFFFFF80, regWrite_memory2=1. LBU same → 0x00000080.
- Load with dcache_ready low 2 cycles, resp arriving while stall_wb=1 → exactly one request; memory2 holds; after stall_wb falls, load_data from buffer; no re-issue.
- Reset asserted in WAIT_RESP, response next cycle → request dropped, response ignored, memory2=NOP, stall_memory1=0 with mem_op=0.
- LW addr 0x102: with MISALIGNED_TRAP_EN → no request, misaligned_memory2=1; without → request addr 0x100, misaligned_memory2=0.

Source files
------------

// File: rtl/memory1_issue_unit.sv
// memory1_issue_unit
// Memory-1 pipeline stage: turns the load/store held in memory1 into a single
// data-cache request, waits for load responses, aligns and extends load data,
// and registers the result into memory2.
// Optional feature macro: MISALIGNED_TRAP_EN. When defined, misaligned half/word
// accesses are not issued and are flagged in memory2. When undefined, they are
// issued as the low lanes of the aligned word.
module memory1_issue_unit #(
  parameter int DATA_WIDTH   = 32,
  parameter int ADDRESS_BITS = 20
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic [DATA_WIDTH-1:0]   ALU_result_memory1,
  input  logic [DATA_WIDTH-1:0]   store_data_memory1,
  input  logic [4:0]              rd_memory1,
  input  logic [6:0]              opcode_memory1,
  input  logic [DATA_WIDTH-1:0]   instruction_memory1,
  input  logic [ADDRESS_BITS-1:0] PC_memory1,
  input  logic                    memRead_memory1,
  input  logic                    memWrite_memory1,
  input  logic                    regWrite_memory1,
  input  logic                    stall_wb,
  output logic                    dcache_req_valid,
  output logic                    dcache_req_write,
  output logic [ADDRESS_BITS-1:0] dcache_req_addr,
  output logic [DATA_WIDTH-1:0]   dcache_req_wdata,
  output logic [3:0]              dcache_req_byte_en,
  input  logic                    dcache_ready,
  input  logic                    dcache_resp_valid,
  input  logic [DATA_WIDTH-1:0]   dcache_resp_data,
  output logic                    stall_memory1,
  output logic [DATA_WIDTH-1:0]   load_data_memory2,
  output logic [DATA_WIDTH-1:0]   ALU_result_memory2,
  output logic [4:0]              rd_memory2,
  output logic [6:0]              opcode_memory2,
  output logic                    regWrite_memory2,
  output logic                    memRead_memory2,
  output logic [DATA_WIDTH-1:0]   instruction_memory2,
  output logic [ADDRESS_BITS-1:0] PC_memory2,
  output logic                    misaligned_memory2
);

  localparam logic [1:0] IDLE      = 2'd0;
  localparam logic [1:0] WAIT_RESP = 2'd1;
  localparam logic [1:0] DONE      = 2'd2;

  localparam logic [DATA_WIDTH-1:0] NOP = DATA_WIDTH'(32'h00000013);

  logic [1:0]            state, state_next;
  logic [2:0]            funct3;
  logic [1:0]            off, eff_off;
  logic                  mem_op, is_half, is_word, misaligned, trap;
  logic                  accept, complete_now;
  logic [DATA_WIDTH-1:0] shifted, aligned, load_buffer;

  assign funct3     = instruction_memory1[14:12];
  assign off        = ALU_result_memory1[1:0];
  assign mem_op     = memRead_memory1 | memWrite_memory1;
  assign is_half    = (funct3[1:0] == 2'b01);
  assign is_word    = (funct3[1:0] == 2'b10);
  assign misaligned = mem_op & ((is_half & off[0]) | (is_word & (off != 2'b00)));

`ifdef MISALIGNED_TRAP_EN
  assign trap    = misaligned;
  assign eff_off = off;
`else
  assign trap    = 1'b0;
  assign eff_off = misaligned ? 2'b00 : off;
`endif

  // Request is only offered from IDLE, and reset kills it immediately.
  assign dcache_req_valid = (state == IDLE) & mem_op & ~trap & ~reset;
  assign dcache_req_write = memWrite_memory1;
  assign dcache_req_addr  = {ALU_result_memory1[ADDRESS_BITS-1:2], 2'b00};

  assign accept       = dcache_req_valid & dcache_ready;
  assign complete_now = (accept & memWrite_memory1) |
                        ((state == WAIT_RESP) & dcache_resp_valid);
  assign stall_memory1 = mem_op & ~complete_now & (state != DONE) & ~trap;

  // Store lane enables and replicated write data.
  always_comb begin
    dcache_req_byte_en = 4'hF;
    dcache_req_wdata   = store_data_memory1;
    if (memWrite_memory1) begin
      case (funct3[1:0])
        2'b00: begin
          dcache_req_byte_en = 4'b0001 << eff_off;
          dcache_req_wdata   = {4{store_data_memory1[7:0]}};
        end
        2'b01: begin
          dcache_req_byte_en = 4'b0011 << eff_off;
          dcache_req_wdata   = {2{store_data_memory1[15:0]}};
        end
        default: ;
      endcase
    end
  end

  // Shift the response word down to the addressed lane and extend it.
  always_comb begin
    shifted = dcache_resp_data >> {eff_off, 3'b000};
    case (funct3)
      3'b000:  aligned = {{(DATA_WIDTH-8){shifted[7]}}, shifted[7:0]};
      3'b001:  aligned = {{(DATA_WIDTH-16){shifted[15]}}, shifted[15:0]};
      3'b100:  aligned = {{(DATA_WIDTH-8){1'b0}}, shifted[7:0]};
      3'b101:  aligned = {{(DATA_WIDTH-16){1'b0}}, shifted[15:0]};
      default: aligned = shifted;
    endcase
  end

  // Next-state logic for the single outstanding access.
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (accept) begin
          if (memWrite_memory1) state_next = stall_wb ? DONE : IDLE;
          else                  state_next = WAIT_RESP;
        end
      end
      WAIT_RESP: begin
        if (dcache_resp_valid) state_next = stall_wb ? DONE : IDLE;
      end
      DONE: begin
        if (!stall_wb) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clock) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // Capture the aligned load result in case memory2 is held when it arrives.
  always_ff @(posedge clock) begin
    if (reset)                                        load_buffer <= '0;
    else if ((state == WAIT_RESP) && dcache_resp_valid) load_buffer <= aligned;
  end

  // memory2 pipeline register: hold on stall_wb, bubble while memory1 stalls.
  always_ff @(posedge clock) begin
    if (reset) begin
      load_data_memory2   <= '0;
      ALU_result_memory2  <= '0;
      rd_memory2          <= '0;
      opcode_memory2      <= '0;
      regWrite_memory2    <= 1'b0;
      memRead_memory2     <= 1'b0;
      instruction_memory2 <= NOP;
      PC_memory2          <= '0;
      misaligned_memory2  <= 1'b0;
    end else if (!stall_wb) begin
      if (stall_memory1) begin
        regWrite_memory2    <= 1'b0;
        memRead_memory2     <= 1'b0;
        misaligned_memory2  <= 1'b0;
        instruction_memory2 <= NOP;
      end else begin
        load_data_memory2   <= (state == DONE) ? load_buffer : (trap ? '0 : aligned);
        ALU_result_memory2  <= ALU_result_memory1;
        rd_memory2          <= rd_memory1;
        opcode_memory2      <= opcode_memory1;
        regWrite_memory2    <= regWrite_memory1 & ~trap;
        memRead_memory2     <= memRead_memory1 & ~trap;
        instruction_memory2 <= instruction_memory1;
        PC_memory2          <= PC_memory1;
        misaligned_memory2  <= trap;
      end
    end
  end

endmodule

// File: tb/tb_memory1_issue_unit.sv
// tb_memory1_issue_unit
// Scoreboard bench: the driver computes expected cache requests and memory2
// contents from a byte-level memory model and queues them; a monitor pops and
// compares whenever a request is accepted or a new instruction reaches memory2.
// Honours MISALIGNED_TRAP_EN the same way the design does.
`timescale 1ns/1ps
module tb_memory1_issue_unit;

  localparam logic [31:0] NOP = 32'h00000013;

  logic        clock = 1'b0;
  logic        reset;
  logic [31:0] ALU_result_memory1, store_data_memory1, instruction_memory1;
  logic [4:0]  rd_memory1;
  logic [6:0]  opcode_memory1;
  logic [19:0] PC_memory1;
  logic        memRead_memory1, memWrite_memory1, regWrite_memory1, stall_wb;
  logic        dcache_req_valid, dcache_req_write;
  logic [19:0] dcache_req_addr;
  logic [31:0] dcache_req_wdata;
  logic [3:0]  dcache_req_byte_en;
  logic        dcache_ready, dcache_resp_valid;
  logic [31:0] dcache_resp_data;
  logic        stall_memory1;
  logic [31:0] load_data_memory2, ALU_result_memory2, instruction_memory2;
  logic [4:0]  rd_memory2;
  logic [6:0]  opcode_memory2;
  logic        regWrite_memory2, memRead_memory2, misaligned_memory2;
  logic [19:0] PC_memory2;

  memory1_issue_unit #(.DATA_WIDTH(32), .ADDRESS_BITS(20)) dut (
    .clock(clock), .reset(reset),
    .ALU_result_memory1(ALU_result_memory1), .store_data_memory1(store_data_memory1),
    .rd_memory1(rd_memory1), .opcode_memory1(opcode_memory1),
    .instruction_memory1(instruction_memory1), .PC_memory1(PC_memory1),
    .memRead_memory1(memRead_memory1), .memWrite_memory1(memWrite_memory1),
    .regWrite_memory1(regWrite_memory1), .stall_wb(stall_wb),
    .dcache_req_valid(dcache_req_valid), .dcache_req_write(dcache_req_write),
    .dcache_req_addr(dcache_req_addr), .dcache_req_wdata(dcache_req_wdata),
    .dcache_req_byte_en(dcache_req_byte_en), .dcache_ready(dcache_ready),
    .dcache_resp_valid(dcache_resp_valid), .dcache_resp_data(dcache_resp_data),
    .stall_memory1(stall_memory1), .load_data_memory2(load_data_memory2),
    .ALU_result_memory2(ALU_result_memory2), .rd_memory2(rd_memory2),
    .opcode_memory2(opcode_memory2), .regWrite_memory2(regWrite_memory2),
    .memRead_memory2(memRead_memory2), .instruction_memory2(instruction_memory2),
    .PC_memory2(PC_memory2), .misaligned_memory2(misaligned_memory2)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [31:0] instr;
    logic [19:0] pc;
    logic [31:0] alu;
    logic [4:0]  rd;
    logic [6:0]  opcode;
    logic        reg_write;
    logic        mem_read;
    logic        misaligned;
    logic [31:0] load_data;
    bit          check_ld;
  } m2_t;

  typedef struct {
    logic        write;
    logic [19:0] addr;
    logic [31:0] wdata;
    logic [3:0]  byte_en;
    bit          check_wdata;
  } req_t;

  m2_t         exp_m2[$];
  req_t        exp_req[$];
  logic [31:0] ref_mem[16];
  logic [31:0] cache_mem[16];
  int          compared = 0;
  int          mismatched = 0;
  int          accept_count = 0;
  int          cfg_resp_lat = 1;
  int          seq = 1;
  logic [31:0] last_instr = NOP;
`ifdef MISALIGNED_TRAP_EN
  localparam bit TRAP_BUILD = 1'b1;
`else
  localparam bit TRAP_BUILD = 1'b0;
`endif

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    compared++;
    if (actual !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
    end
  endtask

  // Watches accepted requests and memory2 arrivals; pops the scoreboard queues.
  task automatic monitorLoop();
    m2_t        m;
    req_t       r;
    logic [3:0] widx;
    forever begin
      @(negedge clock);
      if (!reset) begin
        if (dcache_req_valid && dcache_ready) begin
          accept_count++;
          widx = dcache_req_addr[5:2];
          if (dcache_req_write)
            for (int b = 0; b < 4; b++)
              if (dcache_req_byte_en[b]) cache_mem[widx][8*b +: 8] = dcache_req_wdata[8*b +: 8];
          if (exp_req.size() == 0) begin
            compared++; mismatched++;
            $display("[TB] FAIL unexpected_request: got addr 0x%05h, expected no request", dcache_req_addr);
          end else begin
            r = exp_req.pop_front();
            checkOutput("req_write", dcache_req_write, r.write);
            checkOutput("req_addr", dcache_req_addr, r.addr);
            checkOutput("req_byte_en", dcache_req_byte_en, r.byte_en);
            if (r.check_wdata) checkOutput("req_wdata", dcache_req_wdata, r.wdata);
          end
        end
        if (instruction_memory2 !== last_instr) begin
          last_instr = instruction_memory2;
          if (instruction_memory2 !== NOP) begin
            if (exp_m2.size() == 0) begin
              compared++; mismatched++;
              $display("[TB] FAIL unexpected_memory2: got instr 0x%08h, expected none", instruction_memory2);
            end else begin
              m = exp_m2.pop_front();
              checkOutput("m2_instr", instruction_memory2, m.instr);
              checkOutput("m2_pc", PC_memory2, m.pc);
              checkOutput("m2_alu", ALU_result_memory2, m.alu);
              checkOutput("m2_rd", rd_memory2, m.rd);
              checkOutput("m2_opcode", opcode_memory2, m.opcode);
              checkOutput("m2_regWrite", regWrite_memory2, m.reg_write);
              checkOutput("m2_memRead", memRead_memory2, m.mem_read);
              checkOutput("m2_misaligned", misaligned_memory2, m.misaligned);
              if (m.check_ld) checkOutput("m2_load_data", load_data_memory2, m.load_data);
            end
          end
        end
        if (instruction_memory2 === NOP)
          checkOutput("bubble_ctrl", {regWrite_memory2, memRead_memory2, misaligned_memory2}, 3'b000);
      end
    end
  endtask

  // Cache model: answers each accepted load after a fixed or random latency.
  task automatic responderLoop();
    int         lat;
    logic [3:0] idx;
    forever begin
      @(negedge clock);
      if (!reset && dcache_req_valid && dcache_ready && !dcache_req_write) begin
        idx = dcache_req_addr[5:2];
        lat = (cfg_resp_lat > 0) ? cfg_resp_lat : int'($urandom_range(1, 4));
        repeat (lat) @(posedge clock);
        #1;
        dcache_resp_valid = 1'b1;
        dcache_resp_data  = cache_mem[idx];
        @(posedge clock);
        #1;
        dcache_resp_valid = 1'b0;
        dcache_resp_data  = $urandom;
      end
    end
  endtask

  // Issues one memory1 instruction (kind 0 load, 1 store, 2 ALU) and holds it
  // until it leaves memory1; queues the expected request and memory2 contents.
  task automatic applyStimulus(input int kind, input logic [2:0] f3, input logic [31:0] addr,
                               input logic [31:0] data, input int ready_pct, input int ready_low,
                               input int wb_hold, input int wb_pct, output int stall_cnt);
    m2_t         m;
    req_t        r;
    logic [1:0]  off, eoff;
    bit          mis, trapped, adv;
    int          nbytes, acc0, cyc;
    logic [3:0]  idx, be;
    logic [31:0] word, val, wd;
    logic [6:0]  opc;
    logic [4:0]  rd;
    off    = addr[1:0];
    idx    = addr[5:2];
    nbytes = (f3[1:0] == 2'b00) ? 1 : (f3[1:0] == 2'b01) ? 2 : 4;
    mis    = (kind != 2) && ((int'(off) % nbytes) != 0);
    trapped = TRAP_BUILD && mis;
    eoff   = (mis && !TRAP_BUILD) ? 2'b00 : off;
    opc    = (kind == 0) ? 7'b0000011 : (kind == 1) ? 7'b0100011 : 7'b0110011;
    rd     = 5'($urandom_range(1, 31));
    be = '0; wd = '0; val = '0;
    if (kind == 1 && !trapped) begin
      for (int i = 0; i < nbytes; i++) begin
        ref_mem[idx][8*(int'(eoff)+i) +: 8] = data[8*i +: 8];
        be[int'(eoff)+i] = 1'b1;
      end
      for (int i = 0; i < 4; i++) wd[8*i +: 8] = data[8*(i % nbytes) +: 8];
    end
    if (kind == 0 && !trapped) begin
      word = ref_mem[idx];
      for (int i = 0; i < nbytes; i++) val[8*i +: 8] = word[8*(int'(eoff)+i) +: 8];
      if (!f3[2] && nbytes < 4 && val[8*nbytes-1])
        for (int j = 8*nbytes; j < 32; j++) val[j] = 1'b1;
    end
    m.instr      = {seq[11:0], 5'($urandom), f3, rd, opc};
    m.pc         = 20'($urandom);
    m.alu        = addr;
    m.rd         = rd;
    m.opcode     = opc;
    m.reg_write  = (kind != 1) && !trapped;
    m.mem_read   = (kind == 0) && !trapped;
    m.misaligned = trapped;
    m.load_data  = val;
    m.check_ld   = (kind == 0) && !trapped;
    exp_m2.push_back(m);
    if (kind != 2 && !trapped) begin
      r.write       = (kind == 1);
      r.addr        = {addr[19:2], 2'b00};
      r.wdata       = wd;
      r.byte_en     = (kind == 1) ? be : 4'hF;
      r.check_wdata = (kind == 1);
      exp_req.push_back(r);
    end
    ALU_result_memory1  = addr;
    store_data_memory1  = data;
    rd_memory1          = rd;
    opcode_memory1      = opc;
    instruction_memory1 = m.instr;
    PC_memory1          = m.pc;
    memRead_memory1     = (kind == 0);
    memWrite_memory1    = (kind == 1);
    regWrite_memory1    = (kind != 1);
    acc0 = accept_count; stall_cnt = 0; cyc = 0; adv = 1'b0;
    while (!adv && cyc < 300) begin
      dcache_ready = (cyc < ready_low) ? 1'b0 : ($urandom_range(0, 99) < ready_pct);
      stall_wb     = (cyc < wb_hold) ? 1'b1 : ($urandom_range(0, 99) < wb_pct);
      @(negedge clock);
      if (stall_memory1) stall_cnt++;
      adv = !stall_memory1 && !stall_wb;
      @(posedge clock);
      #1;
      cyc++;
    end
    if (!adv) begin
      compared++; mismatched++;
      $display("[TB] FAIL timeout: instr 0x%08h still in memory1 after %0d cycles, expected retirement", m.instr, cyc);
    end
    checkOutput("issue_once", accept_count - acc0, (kind != 2 && !trapped) ? 1 : 0);
    seq++;
  endtask

  task automatic clearMemory1();
    ALU_result_memory1 = '0; store_data_memory1 = '0; rd_memory1 = '0; opcode_memory1 = '0;
    instruction_memory1 = NOP; PC_memory1 = '0;
    memRead_memory1 = 1'b0; memWrite_memory1 = 1'b0; regWrite_memory1 = 1'b0;
  endtask

  initial begin
    int sc, kind;
    logic [2:0] f3;
    logic [31:0] addr;
    reset = 1'b1; stall_wb = 1'b0; dcache_ready = 1'b0;
    dcache_resp_valid = 1'b0; dcache_resp_data = '0;
    clearMemory1();
    for (int i = 0; i < 16; i++) begin
      ref_mem[i]   = $urandom;
      cache_mem[i] = ref_mem[i];
    end
    fork
      monitorLoop();
      responderLoop();
    join_none

    repeat (3) @(posedge clock);
    @(negedge clock);
    checkOutput("rst_req_valid", dcache_req_valid, 1'b0);
    checkOutput("rst_stall", stall_memory1, 1'b0);
    checkOutput("rst_instr", instruction_memory2, NOP);
    checkOutput("rst_load_data", load_data_memory2, 32'h0);
    checkOutput("rst_alu", ALU_result_memory2, 32'h0);
    checkOutput("rst_ctrl", {regWrite_memory2, memRead_memory2, misaligned_memory2}, 3'b000);
    checkOutput("rst_pc_rd_op", {PC_memory2, rd_memory2, opcode_memory2}, 32'h0);
    @(posedge clock);
    #1;
    reset = 1'b0;

    $display("[TB] directed stores and loads");
    cfg_resp_lat = 3;
    applyStimulus(1, 3'b010, 32'h0000_0100, 32'hDEADBEEF, 100, 0, 0, 0, sc);
    checkOutput("sw_stall_cycles", sc, 0);
    applyStimulus(1, 3'b000, 32'h0000_0103, 32'h0000_00A5, 100, 0, 0, 0, sc);
    checkOutput("sb_stall_cycles", sc, 0);
    applyStimulus(1, 3'b010, 32'h0000_0100, 32'h12807F00, 100, 0, 0, 0, sc);
    applyStimulus(0, 3'b000, 32'h0000_0102, 32'h0, 100, 0, 0, 0, sc);
    checkOutput("lb_stall_cycles", sc, 3);
    applyStimulus(0, 3'b100, 32'h0000_0102, 32'h0, 100, 0, 0, 0, sc);
    checkOutput("lbu_stall_cycles", sc, 3);
    cfg_resp_lat = 2;
    applyStimulus(0, 3'b010, 32'h0000_0100, 32'h0, 100, 2, 6, 0, sc);
    applyStimulus(0, 3'b010, 32'h0000_0102, 32'h0, 100, 0, 0, 0, sc);
    checkOutput("lw_misaligned_stall", sc, TRAP_BUILD ? 0 : 2);

    $display("[TB] reset while a request is offered");
    ALU_result_memory1 = 32'h108; instruction_memory1 = 32'h00002023;
    memWrite_memory1 = 1'b1; dcache_ready = 1'b0; stall_wb = 1'b0;
    @(negedge clock);
    checkOutput("pre_reset_req_valid", dcache_req_valid, 1'b1);
    @(posedge clock); #1;
    reset = 1'b1;
    @(negedge clock);
    checkOutput("reset_drops_req", dcache_req_valid, 1'b0);
    @(posedge clock); #1;
    clearMemory1();
    @(posedge clock); #1;
    reset = 1'b0;

    $display("[TB] reset during WAIT_RESP");
    begin
      req_t r;
      r.write = 1'b0; r.addr = 20'h00104; r.wdata = '0; r.byte_en = 4'hF; r.check_wdata = 1'b0;
      exp_req.push_back(r);
    end
    ALU_result_memory1 = 32'h104; instruction_memory1 = 32'hABC02003;
    memRead_memory1 = 1'b1; regWrite_memory1 = 1'b1; dcache_ready = 1'b1;
    @(posedge clock); #1;
    reset = 1'b1;
    clearMemory1();
    @(negedge clock);
    checkOutput("wait_reset_req_valid", dcache_req_valid, 1'b0);
    @(posedge clock); #1;
    reset = 1'b0;
    @(negedge clock);
    checkOutput("post_reset_resp_seen", dcache_resp_valid, 1'b1);
    checkOutput("post_reset_stall", stall_memory1, 1'b0);
    checkOutput("post_reset_instr", instruction_memory2, NOP);
    checkOutput("post_reset_regWrite", regWrite_memory2, 1'b0);
    @(posedge clock); #1;

    $display("[TB] randomized traffic");
    cfg_resp_lat = 0;
    for (int n = 0; n < 300; n++) begin
      kind = $urandom_range(0, 5);
      kind = (kind <= 2) ? 0 : (kind <= 4) ? 1 : 2;
      case ($urandom_range(0, 4))
        0: f3 = 3'b000; 1: f3 = 3'b001; 2: f3 = 3'b010; 3: f3 = 3'b100; default: f3 = 3'b101;
      endcase
      if (kind == 1) f3[2] = 1'b0;
      if (kind == 2) f3 = 3'b000;
      addr = 32'h100 + 32'($urandom_range(0, 63));
      addr[31:24] = 8'($urandom);
      applyStimulus(kind, f3, addr, $urandom, 70, 0, 0, 20, sc);
    end

    clearMemory1();
    stall_wb = 1'b0; dcache_ready = 1'b0;
    repeat (6) @(posedge clock);
    #1;
    checkOutput("m2_queue_drained", exp_m2.size(), 0);
    checkOutput("req_queue_drained", exp_req.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
